// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl: credit-limited issue/return control wrapped around the
// fixed-latency, non-stallable `mul` multiplier. Results are tracked by tag
// through a MUL_LAT-deep shift register and buffered in a small FIFO.
// Optional feature macro: MUL_RESULT_BYPASS_EN (combinational result bypass
// when the FIFO is empty, saving one cycle of latency).
module mul_issue_ctrl #(
   parameter int unsigned MUL_LAT    = 1,
   parameter int unsigned FIFO_DEPTH = 2,
   parameter int unsigned TAG_W      = 5
) (
   input  logic             mul_clk,
   input  logic             resetn,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [31:0]      in_x,
   input  logic [31:0]      in_y,
   input  logic [TAG_W-1:0] in_tag,
   output logic             mul_signed_o,
   output logic [31:0]      mul_x_o,
   output logic [31:0]      mul_y_o,
   input  logic [63:0]      mul_result_i,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_data,
   output logic [TAG_W-1:0] out_tag
);

   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned SUM_W = $clog2(FIFO_DEPTH + MUL_LAT + 1);

   typedef struct packed {
      logic             valid;
      logic             half;
      logic [TAG_W-1:0] tag;
   } trk_t;

   typedef struct packed {
      logic [31:0]      data;
      logic [TAG_W-1:0] tag;
   } ent_t;

   trk_t             trk_q  [MUL_LAT];
   ent_t             fifo_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] cnt_q;
   logic             settled_q;

   logic [SUM_W-1:0] inflight;
   logic [SUM_W-1:0] occupancy;
   logic             issue;
   logic             capture;
   logic             push;
   logic             pop;
   logic             fifo_empty;
   ent_t             cap_ent;
   ent_t             head_ent;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Operand pass-through to mul, held at zero while in reset
   always_comb begin
      mul_x_o      = resetn ? in_x : '0;
      mul_y_o      = resetn ? in_y : '0;
      mul_signed_o = resetn && (in_op != 2'd2);
   end

   // Count ops still travelling through mul
   always_comb begin
      inflight = '0;
      for (int i = 0; i < int'(MUL_LAT); i++) begin
         inflight = inflight + SUM_W'(trk_q[i].valid);
      end
   end

   // Credit check: reserve a FIFO slot for every op already in flight
   always_comb begin
      occupancy = SUM_W'(cnt_q) + inflight;
      in_ready  = settled_q && !flush && (occupancy < SUM_W'(FIFO_DEPTH));
      issue     = in_valid && in_ready;
   end

   // Select the requested result half as the op leaves mul
   always_comb begin
      capture      = trk_q[MUL_LAT-1].valid && !flush;
      cap_ent.data = trk_q[MUL_LAT-1].half ? mul_result_i[63:32] : mul_result_i[31:0];
      cap_ent.tag  = trk_q[MUL_LAT-1].tag;
      head_ent     = fifo_q[rd_ptr_q];
      fifo_empty   = (cnt_q == '0);
   end

`ifdef MUL_RESULT_BYPASS_EN
   logic bypass;

   // Present a fresh result directly when nothing is queued ahead of it
   always_comb begin
      bypass    = capture && fifo_empty;
      out_valid = !fifo_empty || bypass;
      out_data  = fifo_empty ? cap_ent.data : head_ent.data;
      out_tag   = fifo_empty ? cap_ent.tag  : head_ent.tag;
      pop       = !fifo_empty && out_ready;
      push      = capture && !(bypass && out_ready);
   end
`else
   // Results always return from the FIFO head
   always_comb begin
      out_valid = !fifo_empty;
      out_data  = head_ent.data;
      out_tag   = head_ent.tag;
      pop       = out_valid && out_ready;
      push      = capture;
   end
`endif

   // Tag tracking shift register; a bubble enters on non-issue cycles
   always_ff @(posedge mul_clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < int'(MUL_LAT); i++) trk_q[i] <= '0;
      end else if (flush) begin
         for (int i = 0; i < int'(MUL_LAT); i++) trk_q[i] <= '0;
      end else begin
         trk_q[0] <= '{valid: issue,
                       half:  (in_op == 2'd1) || (in_op == 2'd2),
                       tag:   in_tag};
         for (int i = 1; i < int'(MUL_LAT); i++) trk_q[i] <= trk_q[i-1];
      end
   end

   // Result FIFO storage, pointers, occupancy and reset-settled flag
   always_ff @(posedge mul_clk or negedge resetn) begin
      if (!resetn) begin
         settled_q <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         cnt_q     <= '0;
         for (int i = 0; i < int'(FIFO_DEPTH); i++) fifo_q[i] <= '0;
      end else begin
         settled_q <= 1'b1;
         if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
         end else begin
            if (push) begin
               fifo_q[wr_ptr_q] <= cap_ent;
               wr_ptr_q         <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
               rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (push && !pop) begin
               cnt_q <= cnt_q + CNT_W'(1);
            end else if (pop && !push) begin
               cnt_q <= cnt_q - CNT_W'(1);
            end
         end
      end
   end

   // Credit scheme guarantees a full FIFO is never written
   a_no_overflow: assert property (@(posedge mul_clk) disable iff (!resetn)
      !(push && !pop && !flush && (cnt_q == CNT_W'(FIFO_DEPTH))));

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Scoreboard bench for mul_issue_ctrl with a behavioural fixed-latency mul.
module tb_mul_issue_ctrl;

   localparam int unsigned MUL_LAT    = 1;
   localparam int unsigned FIFO_DEPTH = 2;
   localparam int unsigned TAG_W      = 5;
`ifdef MUL_RESULT_BYPASS_EN
   localparam int EXP_LAT = MUL_LAT;
`else
   localparam int EXP_LAT = MUL_LAT + 1;
`endif

   logic             mul_clk;
   logic             resetn;
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       in_op;
   logic [31:0]      in_x;
   logic [31:0]      in_y;
   logic [TAG_W-1:0] in_tag;
   logic             mul_signed_o;
   logic [31:0]      mul_x_o;
   logic [31:0]      mul_y_o;
   logic [63:0]      mul_result;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_data;
   logic [TAG_W-1:0] out_tag;

   typedef struct packed {
      logic [31:0]      d;
      logic [TAG_W-1:0] t;
   } sb_t;

   sb_t              exp_q[$];
   logic [31:0]      exp_data;
   logic [TAG_W-1:0] exp_tag;
   int               n_pass = 0;
   int               n_tot  = 0;
   int               stray  = 0;

   mul_issue_ctrl #(.MUL_LAT(MUL_LAT), .FIFO_DEPTH(FIFO_DEPTH), .TAG_W(TAG_W)) dut (
      .mul_clk     (mul_clk),
      .resetn      (resetn),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_op       (in_op),
      .in_x        (in_x),
      .in_y        (in_y),
      .in_tag      (in_tag),
      .mul_signed_o(mul_signed_o),
      .mul_x_o     (mul_x_o),
      .mul_y_o     (mul_y_o),
      .mul_result_i(mul_result),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_tag     (out_tag)
   );

   initial mul_clk = 1'b0;
   always #5 mul_clk = ~mul_clk;

   function automatic logic [63:0] mul_model(input logic s, input logic [31:0] x, input logic [31:0] y);
      logic [63:0] a;
      logic [63:0] b;
      a = s ? {{32{x[31]}}, x} : {32'b0, x};
      b = s ? {{32{y[31]}}, y} : {32'b0, y};
      return a * b;
   endfunction

   function automatic logic [31:0] ref_half(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
      logic [63:0] p;
      p = mul_model(op != 2'd2, x, y);
      return (op == 2'd1 || op == 2'd2) ? p[63:32] : p[31:0];
   endfunction

   // Behavioural mul: fixed latency, cannot stall
   logic [63:0] mpipe [MUL_LAT];
   always @(posedge mul_clk) begin
      mpipe[0] <= mul_model(mul_signed_o, mul_x_o, mul_y_o);
      for (int i = 1; i < int'(MUL_LAT); i++) mpipe[i] <= mpipe[i-1];
   end
   assign mul_result = mpipe[MUL_LAT-1];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   // Monitor: compare popped results, then record accepted ops / flushes
   always @(negedge mul_clk) begin
      sb_t e;
      if (!resetn) begin
         exp_q.delete();
      end else begin
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               stray++;
               check("out_valid_unexpected", 64'(out_valid), 64'(0));
            end else begin
               e = exp_q.pop_front();
               check("out_data", 64'(out_data), 64'(e.d));
               check("out_tag", 64'(out_tag), 64'(e.t));
            end
         end
         if (flush) exp_q.delete();
         else if (in_valid && in_ready) exp_q.push_back('{d: exp_data, t: exp_tag});
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge mul_clk);
      #1;
   endtask

   task automatic set_op(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                         input logic [TAG_W-1:0] tag, input logic [31:0] e);
      in_op = op; in_x = x; in_y = y; in_tag = tag;
      exp_data = e; exp_tag = tag;
   endtask

   // Offer one op and wait (bounded) for it to be accepted
   task automatic issue_op(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                           input logic [TAG_W-1:0] tag, input logic [31:0] e);
      bit got;
      got = 1'b0;
      set_op(op, x, y, tag, e);
      in_valid = 1'b1;
      for (int k = 0; k < 50 && !got; k++) begin
         @(negedge mul_clk);
         got = in_ready;
         @(posedge mul_clk);
         #1;
      end
      in_valid = 1'b0;
      check("issue_accept", 64'(got), 64'(1));
   endtask

   task automatic load_rand();
      logic [1:0]  op;
      logic [31:0] x;
      logic [31:0] y;
      op = 2'($urandom_range(0, 3));
      x  = $urandom;
      y  = $urandom;
      case ($urandom_range(0, 7))
         0: x = 32'h8000_0000;
         1: y = 32'hFFFF_FFFF;
         2: x = 32'h7FFF_FFFF;
         default: ;
      endcase
      set_op(op, x, y, TAG_W'($urandom), ref_half(op, x, y));
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [1:0]  bp_op [4];
      logic [31:0] bp_x  [4];
      logic [31:0] bp_y  [4];
      logic [31:0] bp_e  [4];
      int n;
      bit acc;

      resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_op = 2'd0; in_x = 32'hDEAD_BEEF; in_y = 32'h1234_5678; in_tag = '0;
      exp_data = '0; exp_tag = '0;

      // Reset state
      repeat (3) @(posedge mul_clk);
      @(negedge mul_clk);
      check("rst_in_ready", 64'(in_ready), 64'(0));
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_out_data", 64'(out_data), 64'(0));
      check("rst_out_tag", 64'(out_tag), 64'(0));
      check("rst_mul_x", 64'(mul_x_o), 64'(0));
      check("rst_mul_y", 64'(mul_y_o), 64'(0));
      check("rst_mul_signed", 64'(mul_signed_o), 64'(0));
      @(posedge mul_clk); #1;
      resetn = 1'b1;
      idle(1);
      @(negedge mul_clk);
      check("settled_in_ready", 64'(in_ready), 64'(1));
      check("settled_out_valid", 64'(out_valid), 64'(0));
      check("settled_out_data", 64'(out_data), 64'(0));
      check("pass_mul_x", 64'(mul_x_o), 64'h0000_0000_DEAD_BEEF);
      check("pass_mul_y", 64'(mul_y_o), 64'h0000_0000_1234_5678);
      check("pass_mul_signed", 64'(mul_signed_o), 64'(1));
      in_op = 2'd2;
      @(negedge mul_clk);
      check("pass_mul_unsigned", 64'(mul_signed_o), 64'(0));
      idle(1);

      // MUL.W with latency check
      out_ready = 1'b1;
      issue_op(2'd0, 32'h7FFF_FFFF, 32'd2, 5'd3, 32'hFFFF_FFFE);
      for (int k = 1; k <= EXP_LAT; k++) begin
         @(negedge mul_clk);
         check("latency_out_valid", 64'(out_valid), 64'(k == EXP_LAT));
         if (k < EXP_LAT) begin @(posedge mul_clk); #1; end
      end
      idle(4);

      // High halves and reserved op
      issue_op(2'd1, 32'h8000_0000, 32'd2, 5'd4, 32'hFFFF_FFFF);
      issue_op(2'd2, 32'h8000_0000, 32'd2, 5'd5, 32'h0000_0001);
      issue_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'h0000_0000);
      issue_op(2'd3, 32'hFFFF_FFFF, 32'd2, 5'd7, 32'hFFFF_FFFE);
      idle(6);
      check("directed_drained", 64'(exp_q.size()), 64'(0));

      // Back-pressure: four ops, consumer stalled
      bp_op[0] = 2'd0; bp_x[0] = 32'd10;         bp_y[0] = 32'd20;         bp_e[0] = 32'd200;
      bp_op[1] = 2'd1; bp_x[1] = 32'hFFFF_FFFF;  bp_y[1] = 32'h7FFF_FFFF;  bp_e[1] = 32'hFFFF_FFFF;
      bp_op[2] = 2'd2; bp_x[2] = 32'hFFFF_FFFF;  bp_y[2] = 32'hFFFF_FFFF;  bp_e[2] = 32'hFFFF_FFFE;
      bp_op[3] = 2'd0; bp_x[3] = 32'h0001_0000;  bp_y[3] = 32'h0001_0000;  bp_e[3] = 32'h0000_0000;
      out_ready = 1'b0;
      n = 0;
      set_op(bp_op[0], bp_x[0], bp_y[0], 5'd11, bp_e[0]);
      in_valid = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge mul_clk);
         if (in_valid && in_ready) n++;
         @(posedge mul_clk); #1;
         if (n < 4) set_op(bp_op[n], bp_x[n], bp_y[n], 5'(11 + n), bp_e[n]);
      end
      check("bp_accepted", 64'(n), 64'(FIFO_DEPTH));
      @(negedge mul_clk);
      check("bp_in_ready_low", 64'(in_ready), 64'(0));
      check("bp_out_hold_data", 64'(out_data), 64'(200));
      check("bp_out_hold_tag", 64'(out_tag), 64'(11));
      out_ready = 1'b1;
      for (int c = 0; c < 40 && n < 4; c++) begin
         @(negedge mul_clk);
         if (in_valid && in_ready) n++;
         @(posedge mul_clk); #1;
         if (n < 4) set_op(bp_op[n], bp_x[n], bp_y[n], 5'(11 + n), bp_e[n]);
      end
      in_valid = 1'b0;
      idle(8);
      check("bp_all_issued", 64'(n), 64'(4));
      check("bp_drained", 64'(exp_q.size()), 64'(0));

      // Flush with one op buffered and one in flight
      out_ready = 1'b0;
      issue_op(2'd0, 32'd11, 32'd13, 5'd20, 32'd143);
      issue_op(2'd0, 32'd2, 32'd2, 5'd21, 32'd4);
      flush = 1'b1;
      @(negedge mul_clk);
      check("flush_in_ready", 64'(in_ready), 64'(0));
      check("flush_buffered_visible", 64'(out_valid), 64'(1));
      @(posedge mul_clk); #1;
      flush = 1'b0;
      @(negedge mul_clk);
      check("post_flush_out_valid", 64'(out_valid), 64'(0));
      out_ready = 1'b1;
      idle(5);
      check("flush_no_stale", 64'(stray), 64'(0));
      issue_op(2'd0, 32'd3, 32'd5, 5'd22, 32'd15);
      idle(4);
      check("flush_recovered", 64'(exp_q.size()), 64'(0));

      // Reset with an op in flight
      out_ready = 1'b0;
      issue_op(2'd1, 32'h8000_0000, 32'd2, 5'd23, 32'hFFFF_FFFF);
      resetn = 1'b0;
      idle(2);
      resetn = 1'b1;
      idle(2);
      out_ready = 1'b1;
      idle(4);
      @(negedge mul_clk);
      check("reset_mid_no_result", 64'(stray), 64'(0));
      check("reset_mid_in_ready", 64'(in_ready), 64'(1));
      idle(1);

      // Random stream with occasional flush
      n = 0;
      load_rand();
      in_valid = 1'b1;
      for (int c = 0; c < 60000 && n < 10000; c++) begin
         @(negedge mul_clk);
         acc = in_valid && in_ready;
         @(posedge mul_clk); #1;
         if (acc) begin
            n++;
            load_rand();
         end
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 199) == 0);
      end
      in_valid  = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
      idle(10);
      check("rand_issued", 64'(n), 64'(10000));
      check("rand_drained", 64'(exp_q.size()), 64'(0));
      check("rand_no_stray", 64'(stray), 64'(0));

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
